// File: rtl/tcm_dport_arb.sv
// Two-master arbiter for the TCM data port: round-robin between the core (M0) and the
// loader/debug master (M1), with M1 burst lock and an in-order source FIFO for ack routing.
module tcm_dport_arb #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_wr_i,
    input  logic        m0_rd_i,
    input  logic [3:0]  m0_wr_i,
    input  logic        m0_cacheable_i,
    input  logic [10:0] m0_req_tag_i,
    input  logic        m0_flush_i,
    input  logic        m0_invalidate_i,
    input  logic        m0_writeback_i,
    output logic        m0_accept_o,
    output logic        m0_ack_o,
    output logic        m0_error_o,
    output logic [10:0] m0_resp_tag_o,
    output logic [31:0] m0_data_rd_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_wr_i,
    input  logic        m1_rd_i,
    input  logic [3:0]  m1_wr_i,
    input  logic        m1_lock_i,
    output logic        m1_accept_o,
    output logic        m1_ack_o,
    output logic        m1_error_o,
    output logic [31:0] m1_data_rd_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic        mem_cacheable_o,
    output logic [10:0] mem_req_tag_o,
    output logic        mem_flush_o,
    output logic        mem_invalidate_o,
    output logic        mem_writeback_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    input  logic [31:0] mem_data_rd_i,
    input  logic [10:0] mem_resp_tag_i,

    output logic        spurious_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        ST_ARB,
        ST_LOCK
    } state_t;

    state_t          state_q, state_d;
    logic            last_q;              // 0 = M0 won last handshake, 1 = M1
    logic            src_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            spurious_q;

    logic req0, req1;
    logic gnt0, gnt1;
    logic hs0, hs1, push, pop;
    logic fifo_full, fifo_empty;
    logic head;

    assign req0 = m0_rd_i | (m0_wr_i != 4'h0) | m0_flush_i | m0_invalidate_i | m0_writeback_i;
    assign req1 = m1_rd_i | (m1_wr_i != 4'h0);

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Full blocks the grant even when an ack frees a slot this cycle, keeping
    // the grant path independent of mem_ack_i.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_i && !fifo_full) begin
            if (state_q == ST_LOCK && m1_lock_i) begin
                gnt1 = req1;
            end else if (req0 && req1) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign hs0  = gnt0 & mem_accept_i;
    assign hs1  = gnt1 & mem_accept_i;
    assign push = hs0 | hs1;
    assign pop  = rst_i & mem_ack_i & !fifo_empty;
    assign head = src_mem[rd_ptr_q];

    assign m0_accept_o = hs0;
    assign m1_accept_o = hs1;
    assign m0_ack_o    = pop & !head;
    assign m1_ack_o    = pop & head;

    assign m0_error_o    = mem_error_i;
    assign m0_resp_tag_o = mem_resp_tag_i;
    assign m0_data_rd_o  = mem_data_rd_i;
    assign m1_error_o    = mem_error_i;
    assign m1_data_rd_o  = mem_data_rd_i;
    assign spurious_o    = spurious_q;

    always_comb begin
        mem_addr_o       = '0;
        mem_data_wr_o    = '0;
        mem_rd_o         = 1'b0;
        mem_wr_o         = '0;
        mem_cacheable_o  = 1'b0;
        mem_req_tag_o    = '0;
        mem_flush_o      = 1'b0;
        mem_invalidate_o = 1'b0;
        mem_writeback_o  = 1'b0;
        if (gnt0) begin
            mem_addr_o       = m0_addr_i;
            mem_data_wr_o    = m0_data_wr_i;
            mem_rd_o         = m0_rd_i;
            mem_wr_o         = m0_wr_i;
            mem_cacheable_o  = m0_cacheable_i;
            mem_req_tag_o    = m0_req_tag_i;
            mem_flush_o      = m0_flush_i;
            mem_invalidate_o = m0_invalidate_i;
            mem_writeback_o  = m0_writeback_i;
        end else if (gnt1) begin
            mem_addr_o       = m1_addr_i;
            mem_data_wr_o    = m1_data_wr_i;
            mem_rd_o         = m1_rd_i;
            mem_wr_o         = m1_wr_i;
        end
    end

    // Lock release and re-arbitration happen in the same cycle m1_lock_i drops.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_LOCK && !m1_lock_i) begin
            state_d = ST_ARB;
        end
        if (hs1 && m1_lock_i) begin
            state_d = ST_LOCK;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_ARB;
            last_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) begin
                last_q   <= hs1;
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (mem_ack_i && fifo_empty) begin
                spurious_q <= 1'b1;
            end
        end
    end

    // NOTE: FIFO storage has no reset; entries are only read below count_q,
    // which is reset, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            src_mem[wr_ptr_q] <= hs1;
        end
    end

endmodule

// File: tb/tb_tcm_dport_arb.sv
// Self-checking bench for tcm_dport_arb: directed vector table, hand sequences for
// tag/spurious/reset corners, then random traffic against a queue-based reference model.
module tb_tcm_dport_arb;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m0_data_wr;
    logic        m0_rd;
    logic [3:0]  m0_wr;
    logic        m0_cacheable;
    logic [10:0] m0_req_tag;
    logic        m0_flush, m0_invalidate, m0_writeback;
    logic        m0_accept, m0_ack, m0_error;
    logic [10:0] m0_resp_tag;
    logic [31:0] m0_data_rd;
    logic [31:0] m1_addr, m1_data_wr;
    logic        m1_rd;
    logic [3:0]  m1_wr;
    logic        m1_lock;
    logic        m1_accept, m1_ack, m1_error;
    logic [31:0] m1_data_rd;
    logic [31:0] mem_addr, mem_data_wr;
    logic        mem_rd;
    logic [3:0]  mem_wr;
    logic        mem_cacheable;
    logic [10:0] mem_req_tag;
    logic        mem_flush, mem_invalidate, mem_writeback;
    logic        mem_accept, mem_ack, mem_error;
    logic [31:0] mem_data_rd;
    logic [10:0] mem_resp_tag;
    logic        spurious;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: issuing masters in order, last winner, lock, sticky flag.
    bit src_q[$];
    bit m_last;
    bit m_locked;
    bit m_spur;

    always #5 clk = ~clk;

    tcm_dport_arb #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0_addr), .m0_data_wr_i(m0_data_wr), .m0_rd_i(m0_rd), .m0_wr_i(m0_wr),
        .m0_cacheable_i(m0_cacheable), .m0_req_tag_i(m0_req_tag), .m0_flush_i(m0_flush),
        .m0_invalidate_i(m0_invalidate), .m0_writeback_i(m0_writeback),
        .m0_accept_o(m0_accept), .m0_ack_o(m0_ack), .m0_error_o(m0_error),
        .m0_resp_tag_o(m0_resp_tag), .m0_data_rd_o(m0_data_rd),
        .m1_addr_i(m1_addr), .m1_data_wr_i(m1_data_wr), .m1_rd_i(m1_rd), .m1_wr_i(m1_wr),
        .m1_lock_i(m1_lock), .m1_accept_o(m1_accept), .m1_ack_o(m1_ack),
        .m1_error_o(m1_error), .m1_data_rd_o(m1_data_rd),
        .mem_addr_o(mem_addr), .mem_data_wr_o(mem_data_wr), .mem_rd_o(mem_rd),
        .mem_wr_o(mem_wr), .mem_cacheable_o(mem_cacheable), .mem_req_tag_o(mem_req_tag),
        .mem_flush_o(mem_flush), .mem_invalidate_o(mem_invalidate),
        .mem_writeback_o(mem_writeback), .mem_accept_i(mem_accept), .mem_ack_i(mem_ack),
        .mem_error_i(mem_error), .mem_data_rd_i(mem_data_rd), .mem_resp_tag_i(mem_resp_tag),
        .spurious_o(spurious)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        m0_addr = '0; m0_data_wr = '0; m0_rd = 0; m0_wr = '0; m0_cacheable = 0;
        m0_req_tag = '0; m0_flush = 0; m0_invalidate = 0; m0_writeback = 0;
        m1_addr = '0; m1_data_wr = '0; m1_rd = 0; m1_wr = '0; m1_lock = 0;
        mem_accept = 0; mem_ack = 0; mem_error = 0; mem_data_rd = '0; mem_resp_tag = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        src_q.delete();
        m_last = 1; m_locked = 0; m_spur = 0;
    endtask

    // Arbitration rules: full blocks; held lock reserves the port for M1;
    // otherwise a tie goes to whoever did not win last.
    function automatic void model_grant(output bit g0, output bit g1);
        bit r0, r1;
        g0 = 0; g1 = 0;
        r0 = m0_rd || (m0_wr != 0) || m0_flush || m0_invalidate || m0_writeback;
        r1 = m1_rd || (m1_wr != 0);
        if (!rst || src_q.size() >= DEPTH) return;
        if (m_locked && m1_lock) g1 = r1;
        else if (r0 && r1) begin
            if (m_last) g0 = 1; else g1 = 1;
        end else begin
            g0 = r0; g1 = r1;
        end
    endfunction

    task automatic model_commit();
        bit g0, g1, h0, h1;
        model_grant(g0, g1);
        if (!rst) begin
            src_q.delete();
            m_last = 1; m_locked = 0; m_spur = 0;
            return;
        end
        h0 = g0 && mem_accept;
        h1 = g1 && mem_accept;
        if (mem_ack) begin
            if (src_q.size() == 0) m_spur = 1;
            else void'(src_q.pop_front());
        end
        if (h0) begin src_q.push_back(0); m_last = 0; end
        if (h1) begin src_q.push_back(1); m_last = 1; end
        if (m_locked && !m1_lock) m_locked = 0;
        if (h1 && m1_lock) m_locked = 1;
    endtask

    task automatic check_model();
        bit g0, g1, k0, k1;
        model_grant(g0, g1);
        k0 = rst && mem_ack && src_q.size() > 0 && src_q[0] == 0;
        k1 = rst && mem_ack && src_q.size() > 0 && src_q[0] == 1;
        check("rnd_acc0", m0_accept, g0 && mem_accept);
        check("rnd_acc1", m1_accept, g1 && mem_accept);
        check("rnd_ack0", m0_ack, k0);
        check("rnd_ack1", m1_ack, k1);
        check("rnd_spur", spurious, m_spur);
        check("rnd_addr", mem_addr, g0 ? m0_addr : (g1 ? m1_addr : 32'h0));
        check("rnd_wdata", mem_data_wr, g0 ? m0_data_wr : (g1 ? m1_data_wr : 32'h0));
        check("rnd_rd", mem_rd, g0 ? m0_rd : (g1 ? m1_rd : 1'b0));
        check("rnd_wr", mem_wr, g0 ? m0_wr : (g1 ? m1_wr : 4'h0));
        check("rnd_tag", mem_req_tag, g0 ? m0_req_tag : 11'h0);
        check("rnd_maint", {mem_cacheable, mem_flush, mem_invalidate, mem_writeback},
              g0 ? {m0_cacheable, m0_flush, m0_invalidate, m0_writeback} : 4'h0);
        if (k0) check("rnd_rtag", m0_resp_tag, mem_resp_tag);
        if (k1) check("rnd_m1data", m1_data_rd, mem_data_rd);
    endtask

    typedef struct {
        logic r0, r1, lock, macc, mack;
        logic a0, a1, k0, k1;
    } vec_t;

    vec_t tbl[25];

    initial begin
        // Round-robin, lock burst, FIFO full/unblock, accept=0, lone M1.
        tbl[0]  = '{1,1,0,1,0, 1,0,0,0};
        tbl[1]  = '{1,1,0,1,1, 0,1,1,0};
        tbl[2]  = '{1,1,0,1,1, 1,0,0,1};
        tbl[3]  = '{1,1,0,1,1, 0,1,1,0};
        tbl[4]  = '{0,0,0,1,1, 0,0,0,1};
        tbl[5]  = '{1,1,1,1,0, 1,0,0,0};
        tbl[6]  = '{1,1,1,1,1, 0,1,1,0};
        tbl[7]  = '{1,1,1,1,1, 0,1,0,1};
        tbl[8]  = '{1,1,1,1,1, 0,1,0,1};
        tbl[9]  = '{1,1,0,1,1, 1,0,0,1};
        tbl[10] = '{0,0,0,1,1, 0,0,1,0};
        tbl[11] = '{1,0,0,1,0, 1,0,0,0};
        tbl[12] = '{1,0,0,1,0, 1,0,0,0};
        tbl[13] = '{1,0,0,1,0, 1,0,0,0};
        tbl[14] = '{1,0,0,1,0, 1,0,0,0};
        tbl[15] = '{1,0,0,1,0, 0,0,0,0};
        tbl[16] = '{1,0,0,1,1, 0,0,1,0};
        tbl[17] = '{1,0,0,1,0, 1,0,0,0};
        tbl[18] = '{0,0,0,1,1, 0,0,1,0};
        tbl[19] = '{0,0,0,1,1, 0,0,1,0};
        tbl[20] = '{0,0,0,1,1, 0,0,1,0};
        tbl[21] = '{0,0,0,1,1, 0,0,1,0};
        tbl[22] = '{1,0,0,0,0, 0,0,0,0};
        tbl[23] = '{0,1,0,1,0, 0,1,0,0};
        tbl[24] = '{0,0,0,1,1, 0,0,0,1};

        idle();
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_acc0", m0_accept, 0);
        check("rst_acc1", m1_accept, 0);
        check("rst_ack", {m0_ack, m1_ack}, 0);
        check("rst_memrd", mem_rd, 0);
        check("rst_spur", spurious, 0);
        m0_rd = 1; m1_rd = 1; mem_accept = 1;
        #1;
        check("rst_req_blocked", {m0_accept, m1_accept, mem_rd}, 0);

        do_reset();
        foreach (tbl[i]) begin
            idle();
            m0_rd      = tbl[i].r0;
            m0_addr    = 32'h1000 + i;
            m1_wr      = {4{tbl[i].r1}};
            m1_addr    = 32'h2000 + i;
            m1_lock    = tbl[i].lock;
            mem_accept = tbl[i].macc;
            mem_ack    = tbl[i].mack;
            #1;
            check($sformatf("vec%0d_acc0", i), m0_accept, tbl[i].a0);
            check($sformatf("vec%0d_acc1", i), m1_accept, tbl[i].a1);
            check($sformatf("vec%0d_ack0", i), m0_ack, tbl[i].k0);
            check($sformatf("vec%0d_ack1", i), m1_ack, tbl[i].k1);
            check($sformatf("vec%0d_spur", i), spurious, 0);
            @(negedge clk);
        end

        // Tag and data routing for a single M0 read.
        idle();
        m0_rd = 1; m0_req_tag = 11'h5A5; m0_addr = 32'h0000_0040; mem_accept = 1;
        #1;
        check("tag_acc0", m0_accept, 1);
        check("tag_reqtag", mem_req_tag, 11'h5A5);
        check("tag_addr", mem_addr, 32'h0000_0040);
        @(negedge clk);
        idle();
        mem_ack = 1; mem_resp_tag = 11'h5A5; mem_data_rd = 32'hDEADBEEF;
        #1;
        check("tag_ack0", m0_ack, 1);
        check("tag_ack1", m1_ack, 0);
        check("tag_resp", m0_resp_tag, 11'h5A5);
        check("tag_data", m0_data_rd, 32'hDEADBEEF);
        @(negedge clk);

        // Ack with nothing outstanding sets a sticky flag.
        idle();
        mem_ack = 1;
        #1;
        check("spur_noack", {m0_ack, m1_ack}, 0);
        @(negedge clk);
        idle();
        #1;
        check("spur_set", spurious, 1);
        repeat (3) @(negedge clk);
        #1;
        check("spur_held", spurious, 1);
        do_reset();
        #1;
        check("spur_cleared", spurious, 0);

        // Reset while a request is outstanding orphans its ack.
        m0_rd = 1; mem_accept = 1;
        #1;
        check("mid_acc0", m0_accept, 1);
        @(negedge clk);
        do_reset();
        mem_ack = 1;
        #1;
        check("mid_noack", {m0_ack, m1_ack}, 0);
        @(negedge clk);
        idle();
        #1;
        check("mid_spur", spurious, 1);

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            int sel;
            sel = $urandom_range(0, 7);
            m0_rd         = (sel == 1) || (sel == 2);
            m0_wr         = (sel == 3) ? 4'($urandom_range(1, 15)) : 4'h0;
            m0_flush      = (sel == 4);
            m0_invalidate = (sel == 5);
            m0_writeback  = (sel == 6);
            m0_addr       = $urandom;
            m0_data_wr    = $urandom;
            m0_cacheable  = 1'($urandom);
            m0_req_tag    = 11'($urandom);
            sel = $urandom_range(0, 3);
            m1_rd         = (sel == 1);
            m1_wr         = (sel == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
            m1_addr       = $urandom;
            m1_data_wr    = $urandom;
            if ($urandom_range(0, 3) == 0) m1_lock = 1'($urandom);
            mem_accept    = ($urandom_range(0, 4) != 0);
            mem_ack       = ($urandom_range(0, 9) < 4);
            mem_error     = 1'($urandom);
            mem_data_rd   = $urandom;
            mem_resp_tag  = 11'($urandom);
            rst           = ($urandom_range(0, 199) != 0);
            #1;
            check_model();
            model_commit();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
